// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg
//   Shared constants and types for the register-file writeback arbiter.
//   ADDR_W / DATA_W : default register address and data widths
//   NREGS           : number of architectural registers (2**ADDR_W)
//   gnt_t           : grant encoding produced by rr_arb2
package rf_arb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } gnt_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. Grant is combinational from the requests
//   and the priority pointer; the pointer advances only when a grant is
//   issued (every grant is a transfer, since ready == grant).
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset; forces no grant, favours A
//   req_a : request from requester A
//   req_b : request from requester B
//   gnt   : one-hot grant (GNT_NONE / GNT_A / GNT_B)
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output gnt_t gnt
);

  // prio_b set = B wins the next tie (A was granted last)
  logic prio_b;

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (req_a && (!req_b || !prio_b)) begin
        gnt = GNT_A;
      end else if (req_b) begin
        gnt = GNT_B;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else begin
      case (gnt)
        GNT_A:   prio_b <= 1'b1;
        GNT_B:   prio_b <= 1'b0;
        default: prio_b <= prio_b;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Arbitrates register-file writeback between the pipeline (A) and a
//   multi-cycle mul/div unit (B), registers the winning write for one
//   cycle, and keeps a pending-write scoreboard.
// Ports
//   clk, rst                 : clock / asynchronous active-high reset
//   a_valid/a_addr/a_data    : requester A write request
//   a_ready                  : A accepted this cycle
//   b_valid/b_addr/b_data    : requester B write request
//   b_ready                  : B accepted this cycle
//   iss_valid/iss_addr       : issuing instruction marks its destination busy
//   rf_wr/rf_addr/rf_din     : registered register-file write port
//   busy                     : scoreboard, bit k = register k write pending
module rf_wb_arbiter #(
  parameter int unsigned ADDR_W = rf_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = rf_arb_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic                 rf_wr,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic [DATA_W-1:0]    rf_din,
  output logic [2**ADDR_W-1:0] busy
);

  import rf_arb_pkg::*;

  localparam int unsigned NR = 2 ** ADDR_W;
  localparam logic [NR-1:0] ONE = {{(NR-1){1'b0}}, 1'b1};

  gnt_t              gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NR-1:0]     set_vec;
  logic [NR-1:0]     clr_vec;
  logic [NR-1:0]     busy_nxt;
  logic [NR-1:0]     busy_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt   (gnt)
  );

  assign a_ready = (gnt == GNT_A);
  assign b_ready = (gnt == GNT_B);
  assign xfer    = (gnt != GNT_NONE);

  always_comb begin
    sel_addr = a_addr;
    sel_data = a_data;
    if (gnt == GNT_B) begin
      sel_addr = b_addr;
      sel_data = b_data;
    end
  end

  // Writes to register 0 complete the handshake but never reach the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr   <= 1'b0;
      rf_addr <= '0;
      rf_din  <= '0;
    end else begin
      rf_wr <= xfer && (sel_addr != '0);
      if (xfer) begin
        rf_addr <= sel_addr;
        rf_din  <= sel_data;
      end
    end
  end

  // Set is applied after clear so an issue landing on the completing
  // register keeps it busy; bit 0 is forced low so it never sets.
  always_comb begin
    set_vec  = '0;
    clr_vec  = '0;
    if (iss_valid && (iss_addr != '0)) begin
      set_vec = ONE << iss_addr;
    end
    if (rf_wr) begin
      clr_vec = ONE << rf_addr;
    end
    busy_nxt    = (busy_q & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, iss_valid;
  logic [AW-1:0] a_addr, b_addr, iss_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_din;
  logic [NR-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .rf_wr     (rf_wr),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // State of the world as seen after the most recent rising edge.
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  bit   [NR-1:0] m_busy;
  bit            m_last_b;   // B was the last one served -> A wins a tie
  int            a_wait, b_wait;

  always @(negedge clk) begin
    logic    exp_a, exp_b;
    bit [NR-1:0] nb;
    if (rst) begin
      m_wr = 0; m_addr = '0; m_din = '0; m_busy = '0; m_last_b = 1;
      a_wait = 0; b_wait = 0;
    end
    chk("rf_wr", rf_wr, m_wr);
    chk("busy", busy, m_busy);
    if (m_wr || rst) begin
      chk("rf_addr", rf_addr, m_addr);
      chk("rf_din", rf_din, m_din);
    end
    exp_a = !rst && a_valid && (!b_valid || m_last_b);
    exp_b = !rst && b_valid && (!a_valid || !m_last_b);
    chk("a_ready", a_ready, exp_a);
    chk("b_ready", b_ready, exp_b);
    if (!rst) begin
      if (a_valid) begin
        if (a_ready) begin chk("a_grant_latency", a_wait <= 1, 1); a_wait = 0; end
        else a_wait++;
      end
      if (b_valid) begin
        if (b_ready) begin chk("b_grant_latency", b_wait <= 1, 1); b_wait = 0; end
        else b_wait++;
      end
      nb = m_busy;
      if (m_wr) nb[m_addr] = 1'b0;
      if (iss_valid && iss_addr != 0) nb[iss_addr] = 1'b1;
      if (exp_a) begin
        m_wr = (a_addr != 0); m_addr = a_addr; m_din = a_data; m_last_b = 0;
      end else if (exp_b) begin
        m_wr = (b_addr != 0); m_addr = b_addr; m_din = b_data; m_last_b = 1;
      end else begin
        m_wr = 0;
      end
      m_busy = nb;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; iss_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    logic [NR-1:0] busy_snap;
    logic ga, gb;
    int rst_cnt;
    rst = 1; a_addr = '0; b_addr = '0; iss_addr = '0; a_data = '0; b_data = '0;
    idle_inputs();
    #1;
    chk("reset_rf_wr", rf_wr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_a_ready", a_ready, 0);
    repeat (2) step();
    rst = 0;

    // Contention right after reset: A, B, A, B with no bubble.
    a_valid = 1; a_addr = 5'd1; a_data = 32'hA0;
    b_valid = 1; b_addr = 5'd2; b_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_a_ready", a_ready, (i % 2) == 0);
      chk("rr_b_ready", b_ready, (i % 2) == 1);
      if (i > 0) chk("rr_rf_wr", rf_wr, 1);
      step();
      a_data = a_data + 1; b_data = b_data + 1;
      if (i == 3) idle_inputs();
    end
    @(negedge clk); chk("rr_rf_wr_last", rf_wr, 1);
    step();
    @(negedge clk); chk("rr_rf_wr_idle", rf_wr, 0);

    // Single requester A is granted immediately; write appears next cycle.
    step();
    a_valid = 1; a_addr = 5'd5; a_data = 32'h12345678;
    @(negedge clk); chk("single_a_ready", a_ready, 1);
    step(); idle_inputs();
    @(negedge clk);
    chk("single_rf_wr", rf_wr, 1);
    chk("single_rf_addr", rf_addr, 5);
    chk("single_rf_din", rf_din, 32'h12345678);

    // Scoreboard lifetime for register 9.
    step();
    iss_valid = 1; iss_addr = 5'd9;
    step(); iss_valid = 0;
    @(negedge clk); chk("busy9_set", busy[9], 1);
    step();
    a_valid = 1; a_addr = 5'd9; a_data = 32'h99;
    step(); a_valid = 0;
    @(negedge clk); chk("busy9_during_wr", busy[9], 1);
    step();
    @(negedge clk); chk("busy9_clear", busy[9], 0);

    // Issue to 7 on the edge that completes a write to 7: stays busy.
    iss_valid = 1; iss_addr = 5'd7;
    step(); iss_valid = 0;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h77;
    step(); b_valid = 0;
    iss_valid = 1; iss_addr = 5'd7;
    @(negedge clk); chk("r7_rf_wr", rf_wr, 1);
    step(); iss_valid = 0;
    @(negedge clk); chk("busy7_set_wins", busy[7], 1);

    // Writes and issues to register 0 are inert.
    step();
    busy_snap = busy;
    b_valid = 1; b_addr = 5'd0; b_data = 32'hDEAD;
    @(negedge clk); chk("r0_b_ready", b_ready, 1);
    step(); b_valid = 0;
    iss_valid = 1; iss_addr = 5'd0;
    @(negedge clk); chk("r0_rf_wr", rf_wr, 0);
    step(); iss_valid = 0;
    @(negedge clk);
    chk("r0_busy0", busy[0], 0);
    chk("r0_busy_same", busy, busy_snap);

    // Reset in the middle of a write cycle.
    step(); do_reset();
    iss_valid = 1; iss_addr = 5'd4; step();
    iss_addr = 5'd5; step();
    iss_addr = 5'd9; step();
    iss_valid = 0;
    b_valid = 1; b_addr = 5'd3; b_data = 32'h33;
    step(); b_valid = 0;
    chk("mid_rf_wr_before", rf_wr, 1);
    chk("mid_busy_before", busy, 32'h0000_0230);
    #1 rst = 1;
    #1;
    chk("mid_rf_wr_after", rf_wr, 0);
    chk("mid_busy_after", busy, 0);
    step(); rst = 0;
    a_valid = 1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1; b_addr = 5'd2; b_data = 32'h2;
    @(negedge clk); chk("post_reset_a_first", a_ready, 1);
    step(); a_valid = 0;
    step(); b_valid = 0;

    // Randomized traffic with protocol-correct requesters.
    rst_cnt = 0;
    repeat (3000) begin
      @(negedge clk);
      ga = a_ready; gb = b_ready;
      step();
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_addr  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
        a_data  = $urandom;
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_addr  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
        b_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_addr  = AW'($urandom);
      if (rst_cnt > 0) begin
        rst_cnt--;
        rst = (rst_cnt > 0);
      end else if ($urandom_range(0, 249) == 0) begin
        rst = 1;
        rst_cnt = $urandom_range(1, 3);
      end
    end
    rst = 0;
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: ADDR_W, 5, register address width.
REQ-002 Parameter: DATA_W, 32, register data width.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: a_valid  in  1  requester A (pipeline writeback) write request.
REQ-006 Port: a_addr  in  ADDR_W  requester A destination register.
REQ-007 Port: a_data  in  DATA_W  requester A write data.
REQ-008 Port: a_ready  out  1  requester A accepted this cycle.
REQ-009 Port: b_valid  in  1  requester B (multi-cycle mul/div unit) write request.
REQ-010 Port: b_addr  in  ADDR_W  requester B destination register.
REQ-011 Port: b_data  in  DATA_W  requester B write data.
REQ-012 Port: b_ready  out  1  requester B accepted this cycle.
REQ-013 Port: iss_valid  in  1  an instruction with a pending register write issues this cycle.
REQ-014 Port: iss_addr  in  ADDR_W  destination of the issuing instruction.
REQ-015 Port: rf_wr  out  1  register-file write enable, registered.
REQ-016 Port: rf_addr  out  ADDR_W  register-file write address, registered.
REQ-017 Port: rf_din  out  DATA_W  register-file write data, registered.
REQ-018 Port: busy  out  2**ADDR_W  scoreboard; bit k set = register k has a pending write.

Function
REQ-019 Handshake SHALL be valid/ready; transfer occurs on rising edge when valid && ready; requester SHALL hold valid, addr, data stable until ready.
REQ-020 a_ready and b_ready SHALL be combinational from valids and priority pointer; at most one SHALL be high per cycle.
REQ-021 Only one valid: that requester SHALL be granted the same cycle.
REQ-022 Both valid: round-robin; the requester not granted last SHALL win; pointer SHALL update only on a transfer.
REQ-023 Any valid request SHALL be granted within 2 cycles of assertion.
REQ-024 Latency: a transfer at edge N SHALL drive rf_wr=1, rf_addr, rf_din during cycle N+1 exactly; rf_wr=0 in cycles without a preceding transfer.
REQ-025 Transfer with addr 0 SHALL complete the handshake but SHALL drive rf_wr=0 (register 0 never written).
REQ-026 iss_valid with iss_addr!=0 SHALL set busy[iss_addr] at the edge; iss_addr 0 SHALL be ignored; busy[0] SHALL be constant 0.
REQ-027 busy[rf_addr] SHALL clear at the edge ending a cycle with rf_wr=1.
REQ-028 Set and clear of the same bit on the same edge: set SHALL win.
REQ-029 iss_valid to an already-busy register SHALL leave it busy (single bit, no count).
REQ-030 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.

Reset
REQ-031 While rst=1: rf_wr=0, rf_addr=0, rf_din=0, busy=0, pointer favours A; a_ready and b_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard any registered write immediately (rf_wr drops asynchronously) and clear the scoreboard.
REQ-033 First edge after rst deasserts SHALL accept requests normally.

Structure
REQ-034 Package rf_arb_pkg SHALL hold ADDR_W, DATA_W, NREGS=2**ADDR_W and the grant encoding (GNT_NONE, GNT_A, GNT_B).
REQ-035 Round-robin grant logic SHALL be a sub-module rr_arb2 (two requests, pointer register, one-hot grant).
REQ-036 Write register stage and scoreboard SHALL reside in rf_wb_arbiter; no other sub-modules.

Verification
REQ-037 a_valid only, a_addr=5, a_data=0x12345678 -> a_ready=1 same cycle; next cycle rf_wr=1, rf_addr=5, rf_din=0x12345678.
REQ-038 a_valid,b_valid held 4 cycles after reset -> grants A,B,A,B; rf_wr high 4 consecutive cycles.
REQ-039 iss_valid iss_addr=9, later write to 9 -> busy[9]=1 from issue edge until edge ending rf_wr cycle, then 0.
REQ-040 Write completing to reg 7 on same edge as iss_valid iss_addr=7 -> busy[7] stays 1.
REQ-041 b_valid b_addr=0 -> b_ready=1, rf_wr stays 0, busy unchanged; iss_addr=0 -> busy[0]=0.
REQ-042 rst pulsed while rf_wr=1 and busy=0x0000_0230 -> rf_wr=0, busy=0 immediately; next contention grants A first.
